// File: rtl/pc_branch_fixup.sv
//------------------------------------------------------------------------------
// pc_branch_fixup : 6502 PC (PCL/PCH) with +1 increment and two-cycle
//                   relative-branch page fix-up.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_branch_fixup #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
  input  logic        clk_IN,
  input  logic        rstN_IN,
  input  logic        pcLoad_EN,
  input  logic [15:0] pcLoad_IN,
  input  logic        branch_EN,
  input  logic [7:0]  offset_IN,
  input  logic        pcInc_EN,
  output logic [15:0] pc_OUT,
  output logic        pcLowCarry_OUT,
  output logic        busy_OUT,
  output logic        fixup_OUT
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FIXUP = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] pcl;
  logic [7:0] pch;
  logic       dir_up;
  logic       low_carry;
  logic       fixup_pulse;

  logic [8:0] branch_sum;
  logic [8:0] inc_sum;

  assign branch_sum = {1'b0, pcl} + {1'b0, offset_IN};
  assign inc_sum    = {1'b0, pcl} + 9'd1;

  always_ff @(posedge clk_IN or negedge rstN_IN) begin
    if (!rstN_IN) begin
      state       <= IDLE;
      pcl         <= RESET_VECTOR[7:0];
      pch         <= RESET_VECTOR[15:8];
      dir_up      <= 1'b0;
      low_carry   <= 1'b0;
      fixup_pulse <= 1'b0;
    end else begin
      low_carry   <= 1'b0;
      fixup_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (pcLoad_EN) begin
            pch <= pcLoad_IN[15:8];
            pcl <= pcLoad_IN[7:0];
          end else if (branch_EN) begin
            pcl <= branch_sum[7:0];
            // Carry out of PCL with a positive offset, or no carry with a
            // negative one, means the target lies on the adjacent page.
            if (!offset_IN[7] && branch_sum[8]) begin
              dir_up <= 1'b1;
              state  <= FIXUP;
            end else if (offset_IN[7] && !branch_sum[8]) begin
              dir_up <= 1'b0;
              state  <= FIXUP;
            end
          end else if (pcInc_EN) begin
            pcl       <= inc_sum[7:0];
            pch       <= pch + {7'd0, inc_sum[8]};
            low_carry <= inc_sum[8];
          end
        end
        FIXUP: begin
          state <= IDLE;
          if (pcLoad_EN) begin
            pch <= pcLoad_IN[15:8];
            pcl <= pcLoad_IN[7:0];
          end else begin
            pch         <= dir_up ? pch + 8'd1 : pch - 8'd1;
            fixup_pulse <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pc_OUT         = {pch, pcl};
  assign pcLowCarry_OUT = low_carry;
  assign busy_OUT       = (state == FIXUP);
  assign fixup_OUT      = fixup_pulse;

endmodule

`default_nettype wire
